// File: rtl/carrier_nco.sv
// carrier_nco
//   Phase-accumulator NCO producing the sine-ROM read address for the AM
//   modulator carrier. The key-control offset is turned into a clamped tuning
//   word. While running, a new word is applied only on an accumulator wrap, so
//   the carrier phase stays continuous across a frequency change.
//
// Ports
//   clk            in   system clock (27 MHz)
//   rst            in   asynchronous active-high reset
//   addr_change    in   [9:0] two's-complement frequency offset from key control
//   enable         in   run (1) / hold (0) for the accumulator and divider
//   rom_addr       out  [ADDR_W-1:0] sine ROM address (top bits of phase)
//   rom_addr_valid out  one-cycle strobe, rom_addr updated this cycle
//   wrap_pulse     out  one-cycle strobe, accumulator wrapped on the last advance
//   ftw_active     out  [ACC_W-1:0] tuning word currently in use
module carrier_nco #(
  parameter int ACC_W      = 24,
  parameter int ADDR_W     = 10,
  parameter int BASE_FTW   = 62138,
  parameter int STEP_SHIFT = 4,
  parameter int FTW_MIN    = 16,
  parameter int FTW_MAX    = 2**(ACC_W-1)-1,
  parameter int SAMPLE_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        addr_change,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_addr_valid,
  output logic              wrap_pulse,
  output logic [ACC_W-1:0]  ftw_active
);

  // Two guard bits so the offset sum and its clamp compare cannot overflow.
  localparam int TW    = ACC_W + 2;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic signed [TW-1:0] BASE_S   = TW'(BASE_FTW);
  localparam logic signed [TW-1:0] MIN_S    = TW'(FTW_MIN);
  localparam logic signed [TW-1:0] MAX_S    = TW'(FTW_MAX);
  localparam logic [ACC_W-1:0]     FTW_RST  = ACC_W'(BASE_FTW);
  // The target register tracks addr_change=0 after reset, clamped like any other target.
  localparam logic [ACC_W-1:0]     TGT_RST  = (BASE_FTW < FTW_MIN) ? ACC_W'(FTW_MIN) :
                                              (BASE_FTW > FTW_MAX) ? ACC_W'(FTW_MAX) :
                                              ACC_W'(BASE_FTW);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_target;
  logic [9:0]       r_cap;
  logic             r_pending;
  logic [DIV_W-1:0] r_div;

  logic signed [TW-1:0] w_sext;
  logic signed [TW-1:0] w_sum;
  logic [ACC_W-1:0]     w_target_next;
  logic [ACC_W:0]       w_adv;
  logic                 w_tick;
  logic                 w_change;
  logic                 w_load;

  assign w_sext = {{(TW-10){addr_change[9]}}, addr_change};
  assign w_sum  = BASE_S + (w_sext <<< STEP_SHIFT);

  always_comb begin
    w_target_next = w_sum[ACC_W-1:0];
    if (w_sum < MIN_S) begin
      w_target_next = ACC_W'(FTW_MIN);
    end else if (w_sum > MAX_S) begin
      w_target_next = ACC_W'(FTW_MAX);
    end
  end

  assign w_tick   = enable && (r_div == DIV_LAST);
  // Extra top bit carries the wrap out of the phase add.
  assign w_adv    = {1'b0, r_acc} + {1'b0, ftw_active};
  assign w_change = (addr_change != r_cap);
  // Held: follow the target directly. Running: swap words only at a wrap so
  // the phase never jumps; the add on that edge still uses the old word.
  assign w_load   = !enable || (w_tick && w_adv[ACC_W] && r_pending);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc          <= '0;
      r_target       <= TGT_RST;
      r_cap          <= '0;
      r_pending      <= 1'b0;
      r_div          <= '0;
      rom_addr       <= '0;
      rom_addr_valid <= 1'b0;
      wrap_pulse     <= 1'b0;
      ftw_active     <= FTW_RST;
    end else begin
      r_cap    <= addr_change;
      r_target <= w_target_next;

      // A change landing on the same edge as a wrap load stays pending.
      if (w_change) begin
        r_pending <= 1'b1;
      end else if (w_load) begin
        r_pending <= 1'b0;
      end

      if (w_load) begin
        ftw_active <= r_target;
      end

      if (enable) begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
      end

      rom_addr_valid <= w_tick;
      wrap_pulse     <= w_tick & w_adv[ACC_W];

      if (w_tick) begin
        r_acc    <= w_adv[ACC_W-1:0];
        rom_addr <= w_adv[ACC_W-1 -: ADDR_W];
      end
    end
  end

endmodule

// File: tb/tb_carrier_nco.sv
module tb_carrier_nco;

  logic       clk;
  logic       rst;
  logic       en;
  logic [9:0] ac;

  logic [9:0]  dut_addr [4];
  logic        dut_val  [4];
  logic        dut_wrap [4];
  logic [23:0] dut_ftw  [4];

  int checks   = 0;
  int failures = 0;

  // Instance 0: defaults. 1: divided sample rate. 2/3: clamp corners.
  carrier_nco u_def (
    .clk(clk), .rst(rst), .addr_change(ac), .enable(en),
    .rom_addr(dut_addr[0]), .rom_addr_valid(dut_val[0]),
    .wrap_pulse(dut_wrap[0]), .ftw_active(dut_ftw[0]));

  carrier_nco #(.SAMPLE_DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .addr_change(ac), .enable(en),
    .rom_addr(dut_addr[1]), .rom_addr_valid(dut_val[1]),
    .wrap_pulse(dut_wrap[1]), .ftw_active(dut_ftw[1]));

  carrier_nco #(.BASE_FTW(100)) u_lo (
    .clk(clk), .rst(rst), .addr_change(ac), .enable(en),
    .rom_addr(dut_addr[2]), .rom_addr_valid(dut_val[2]),
    .wrap_pulse(dut_wrap[2]), .ftw_active(dut_ftw[2]));

  carrier_nco #(.BASE_FTW(8388600)) u_hi (
    .clk(clk), .rst(rst), .addr_change(ac), .enable(en),
    .rom_addr(dut_addr[3]), .rom_addr_valid(dut_val[3]),
    .wrap_pulse(dut_wrap[3]), .ftw_active(dut_ftw[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut=%0d actual=%0d expected=%0d t=%0t", nm, idx, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  localparam longint PHASE_MOD = 64'd1 << 24;
  longint base_p [4] = '{62138, 62138, 100, 8388600};
  int     sdiv_p [4] = '{1, 3, 1, 1};

  bit         m_live = 1'b0;
  longint     m_phase [4];
  int         m_div   [4];
  longint     m_ftw   [4];
  longint     m_tgt   [4];
  logic [9:0] m_cap   [4];
  bit         m_pend  [4];
  longint     m_rom   [4];
  bit         m_val   [4];
  bit         m_wrap  [4];

  function automatic longint tgt_of(int k, logic [9:0] a);
    longint t;
    t = base_p[k] + longint'($signed(a)) * 16;
    if (t < 16) t = 16;
    else if (t > 8388607) t = 8388607;
    return t;
  endfunction

  function automatic void model_reset(int k);
    m_phase[k] = 0;
    m_div[k]   = 0;
    m_ftw[k]   = base_p[k];
    m_tgt[k]   = tgt_of(k, 10'd0);
    m_cap[k]   = 10'd0;
    m_pend[k]  = 1'b0;
    m_rom[k]   = 0;
    m_val[k]   = 1'b0;
    m_wrap[k]  = 1'b0;
  endfunction

  function automatic void model_step(int k, bit e, logic [9:0] a);
    bit     tick;
    bit     carry;
    bit     load;
    bit     chg;
    longint s;
    chg   = (a != m_cap[k]);
    tick  = e && (m_div[k] == sdiv_p[k] - 1);
    carry = 1'b0;
    if (tick) begin
      s          = m_phase[k] + m_ftw[k];
      carry      = (s >= PHASE_MOD);
      m_phase[k] = s % PHASE_MOD;
      m_rom[k]   = m_phase[k] >> 14;
    end
    m_val[k]  = tick;
    m_wrap[k] = carry;
    if (e) m_div[k] = tick ? 0 : m_div[k] + 1;
    load = !e || (tick && carry && m_pend[k]);
    if (load) m_ftw[k] = m_tgt[k];
    if (chg) m_pend[k] = 1'b1;
    else if (load) m_pend[k] = 1'b0;
    m_cap[k] = a;
    m_tgt[k] = tgt_of(k, a);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) model_reset(k);
      m_live = 1'b1;
    end else if (m_live) begin
      for (int k = 0; k < 4; k++) model_step(k, en, ac);
    end
    #1;
    if (m_live) begin
      for (int k = 0; k < 4; k++) begin
        chk("rom_addr", k, dut_addr[k], m_rom[k]);
        chk("rom_addr_valid", k, dut_val[k], m_val[k]);
        chk("wrap_pulse", k, dut_wrap[k], m_wrap[k]);
        chk("ftw_active", k, dut_ftw[k], m_ftw[k]);
      end
    end
  end

  // ---------------- stimulus and literal expectations ----------------
  initial begin
    int     n;
    int     cnt;
    bit     found;
    longint held;

    rst = 1'b0;
    en  = 1'b0;
    ac  = 10'd0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("lit_reset_ftw", 0, dut_ftw[0], 62138);
    chk("lit_reset_rom", 0, dut_addr[0], 0);
    chk("lit_reset_valid", 0, dut_val[0], 0);

    @(negedge clk) en = 1'b1;
    @(posedge clk); #2;
    chk("lit_first_valid", 0, dut_val[0], 1);
    chk("lit_first_addr", 0, dut_addr[0], 3);
    @(posedge clk); #2;
    chk("lit_second_addr", 0, dut_addr[0], 7);

    repeat (50) @(negedge clk);
    ac = 10'd5;
    n = 0; found = 1'b0;
    while (n < 1000 && !found) begin
      @(posedge clk); #2;
      if (dut_wrap[0]) found = 1'b1;
      n++;
    end
    chk("lit_wrap_seen", 0, found, 1);
    chk("lit_ftw_after_wrap", 0, dut_ftw[0], 62218);

    @(negedge clk);
    en = 1'b0;
    ac = 10'd512;
    held = dut_addr[0];
    repeat (2) @(posedge clk); #2;
    chk("lit_clamp_lo", 2, dut_ftw[2], 16);
    chk("lit_hold_valid", 0, dut_val[0], 0);
    chk("lit_hold_rom", 0, dut_addr[0], held);

    @(negedge clk) ac = 10'd511;
    repeat (2) @(posedge clk); #2;
    chk("lit_clamp_hi", 3, dut_ftw[3], 8388607);

    @(negedge clk) ac = 10'd1019;
    repeat (2) @(posedge clk); #2;
    chk("lit_ftw_minus5", 0, dut_ftw[0], 62058);
    chk("lit_hold_rom2", 0, dut_addr[0], held);

    @(negedge clk) en = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #2;
      if (dut_val[1]) cnt++;
    end
    chk("lit_div3_count", 1, cnt, 10);
    @(negedge clk);
    en = 1'b0;
    held = dut_addr[1];
    repeat (5) @(posedge clk); #2;
    chk("lit_div3_frozen", 1, dut_addr[1], held);
    @(negedge clk) en = 1'b1;
    repeat (20) @(negedge clk);

    repeat (2000) begin
      @(negedge clk);
      en = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 59))
        0: ac = 10'($urandom_range(0, 1023));
        1: ac = ac + 10'd5;
        2: ac = ac - 10'd5;
        default: ;
      endcase
    end

    @(negedge clk);
    en = 1'b1;
    ac = 10'd0;
    repeat (20) @(negedge clk);
    ac = 10'd40;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    ac  = 10'd0;
    #2;
    chk("lit_async_rom", 0, dut_addr[0], 0);
    chk("lit_async_valid", 0, dut_val[0], 0);
    chk("lit_async_ftw", 0, dut_ftw[0], 62138);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (600) @(negedge clk);
    chk("lit_no_stale_pending", 0, dut_ftw[0], 62138);

    ac = 10'd40;
    n = 0; found = 1'b0;
    while (n < 1000 && !found) begin
      @(posedge clk); #2;
      if (dut_wrap[0]) found = 1'b1;
      n++;
    end
    chk("lit_wrap_seen2", 0, found, 1);
    chk("lit_ftw_plus40", 0, dut_ftw[0], 62778);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
